// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds,
// registered read data and a sticky overflow/underflow error flag.
module fifo_umbral #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] umbral_af,
  input  logic [ADDR_WIDTH-1:0] umbral_ae,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  fifo_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  fifo_empty_q, fifo_empty_d;
  logic                  fifo_full_q, fifo_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  fifo_error_q, fifo_error_d;

  logic                  push_ok;
  logic                  pop_ok;
  logic [CW-1:0]         af_level;

  // Accept decisions, next pointers/count, read data and next-cycle flags.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    data_out_d     = data_out_q;
    valid_out_d    = 1'b0;

    // A pop on a full FIFO frees the slot the simultaneous push uses.
    pop_ok  = pop & ~fifo_empty_q;
    push_ok = push & (~fifo_full_q | pop_ok);

    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_ok) begin
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
    end

    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    af_level = DEPTH_C - CW'(umbral_af);

    fifo_empty_d   = (count_d == '0);
    fifo_full_d    = (count_d == DEPTH_C);
    almost_empty_d = (count_d <= CW'(umbral_ae));
    almost_full_d  = (count_d >= af_level);

    // Sticky: overflow (push into full, no pop) or underflow (pop from empty, no push).
    fifo_error_d = fifo_error_q
                 | (push & fifo_full_q & ~pop)
                 | (pop & fifo_empty_q & ~push);
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= '0;
      valid_out_q    <= 1'b0;
      fifo_empty_q   <= 1'b1;
      fifo_full_q    <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      fifo_error_q   <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      valid_out_q    <= valid_out_d;
      fifo_empty_q   <= fifo_empty_d;
      fifo_full_q    <= fifo_full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      fifo_error_q   <= fifo_error_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign fifo_empty   = fifo_empty_q;
  assign fifo_full    = fifo_full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign fifo_error   = fifo_error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral (DEPTH = 4). Flags are compared as the
// vector {fifo_empty, fifo_full, almost_empty, almost_full, fifo_error}.
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic [5:0] data_in;
  logic       push;
  logic       pop;
  logic [1:0] umbral_af;
  logic [1:0] umbral_ae;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       fifo_error;
  logic [4:0] flags;

  int n_cmp = 0;
  int n_err = 0;

  assign flags = {fifo_empty, fifo_full, almost_empty, almost_full, fifo_error};

  fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_error   (fifo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic q, input logic [5:0] d);
    push    = p;
    pop     = q;
    data_in = d;
  endtask

  task automatic apply_reset();
    drive(1'b0, 1'b0, 6'h00);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    umbral_af = 2'd1;
    umbral_ae = 2'd1;
    apply_reset();
    n_cmp++;
    if (flags !== 5'b10100) begin
      n_err++; $display("FAIL reset_flags: got %b want %b", flags, 5'b10100);
    end
    n_cmp++;
    if ({valid_out, data_out} !== 7'h00) begin
      n_err++; $display("FAIL reset_data: got v=%b d=%h want v=0 d=00", valid_out, data_out);
    end
    // Load two words and pop one so data_out/valid_out are non-zero.
    drive(1'b1, 1'b0, 6'h11); step();
    drive(1'b1, 1'b0, 6'h22); step();
    n_cmp++;
    if (flags !== 5'b00000) begin
      n_err++; $display("FAIL pre_async_flags: got %b want %b", flags, 5'b00000);
    end
    drive(1'b0, 1'b1, 6'h00); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b1, 6'h11, 5'b00100}) begin
      n_err++; $display("FAIL pre_async_pop: got v=%b d=%h f=%b want v=1 d=11 f=00100",
                        valid_out, data_out, flags);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b0, 6'h00, 5'b10100}) begin
      n_err++; $display("FAIL async_reset: got v=%b d=%h f=%b want v=0 d=00 f=10100",
                        valid_out, data_out, flags);
    end
    step();
    reset = 1'b0;
    // First push after reset release is accepted on the next edge.
    drive(1'b1, 1'b0, 6'h05); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if (flags !== 5'b00100) begin
      n_err++; $display("FAIL post_reset_push: got %b want %b", flags, 5'b00100);
    end
  endtask

  task automatic test_fill();
    logic [4:0] ef [4];
    ef[0] = 5'b00100;
    ef[1] = 5'b00000;
    ef[2] = 5'b00010;
    ef[3] = 5'b01010;
    umbral_af = 2'd1;
    umbral_ae = 2'd1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'(i + 1));
      step();
      n_cmp++;
      if (flags !== ef[i]) begin
        n_err++; $display("FAIL fill_%0d: got %b want %b", i + 1, flags, ef[i]);
      end
    end
    drive(1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, 6'h3F); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, flags} !== {1'b0, 5'b01011}) begin
      n_err++; $display("FAIL overflow: got v=%b f=%b want v=0 f=01011", valid_out, flags);
    end
  endtask

  task automatic test_drain();
    logic [4:0] ef [4];
    ef[0] = 5'b00011;
    ef[1] = 5'b00001;
    ef[2] = 5'b00101;
    ef[3] = 5'b10101;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 6'h00);
      step();
      n_cmp++;
      if ({valid_out, data_out, flags} !== {1'b1, 6'(i + 1), ef[i]}) begin
        n_err++; $display("FAIL drain_%0d: got v=%b d=%h f=%b want v=1 d=%h f=%b",
                          i + 1, valid_out, data_out, flags, 6'(i + 1), ef[i]);
      end
    end
    // Extra pop on empty: nothing returned, data_out holds last word.
    step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b0, 6'h04, 5'b10101}) begin
      n_err++; $display("FAIL drain_extra: got v=%b d=%h f=%b want v=0 d=04 f=10101",
                        valid_out, data_out, flags);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1'b0, 1'b1, 6'h00); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, flags} !== {1'b0, 5'b10101}) begin
      n_err++; $display("FAIL underflow: got v=%b f=%b want v=0 f=10101", valid_out, flags);
    end
    // Error stays set through valid traffic.
    drive(1'b1, 1'b0, 6'h09); step();
    drive(1'b0, 1'b1, 6'h00); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b1, 6'h09, 5'b10101}) begin
      n_err++; $display("FAIL sticky_error: got v=%b d=%h f=%b want v=1 d=09 f=10101",
                        valid_out, data_out, flags);
    end
  endtask

  task automatic test_back_to_back();
    umbral_af = 2'd1;
    umbral_ae = 2'd1;
    apply_reset();
    // Push+pop on empty: push only, no bypass.
    drive(1'b1, 1'b1, 6'h2A); step();
    n_cmp++;
    if ({valid_out, flags} !== {1'b0, 5'b00100}) begin
      n_err++; $display("FAIL empty_pushpop: got v=%b f=%b want v=0 f=00100", valid_out, flags);
    end
    drive(1'b0, 1'b1, 6'h00); step();
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b1, 6'h2A, 5'b10100}) begin
      n_err++; $display("FAIL empty_pushpop_read: got v=%b d=%h f=%b want v=1 d=2a f=10100",
                        valid_out, data_out, flags);
    end
    drive(1'b1, 1'b0, 6'h10); step();
    drive(1'b1, 1'b0, 6'h11); step();
    // Count 2 with pointers at wr=3, rd=1: six push+pop cycles wrap both pointers.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 6'(8'h12 + i));
      step();
      n_cmp++;
      if ({valid_out, data_out, flags} !== {1'b1, 6'(8'h10 + i), 5'b00000}) begin
        n_err++; $display("FAIL wrap_%0d: got v=%b d=%h f=%b want v=1 d=%h f=00000",
                          i, valid_out, data_out, flags, 6'(8'h10 + i));
      end
    end
    drive(1'b0, 1'b1, 6'h00); step();
    drive(1'b0, 1'b1, 6'h00); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b1, 6'h17, 5'b10100}) begin
      n_err++; $display("FAIL wrap_tail: got v=%b d=%h f=%b want v=1 d=17 f=10100",
                        valid_out, data_out, flags);
    end
    // Push+pop on a full FIFO: both accepted, no error.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'(8'h21 + i));
      step();
    end
    drive(1'b1, 1'b1, 6'h25); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if ({valid_out, data_out, flags} !== {1'b1, 6'h21, 5'b01010}) begin
      n_err++; $display("FAIL full_pushpop: got v=%b d=%h f=%b want v=1 d=21 f=01010",
                        valid_out, data_out, flags);
    end
    drive(1'b0, 1'b1, 6'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({valid_out, data_out} !== {1'b1, 6'(8'h22 + i)}) begin
        n_err++; $display("FAIL full_drain_%0d: got v=%b d=%h want v=1 d=%h",
                          i, valid_out, data_out, 6'(8'h22 + i));
      end
    end
    drive(1'b0, 1'b0, 6'h00);
  endtask

  task automatic test_threshold();
    umbral_af = 2'd1;
    umbral_ae = 2'd1;
    apply_reset();
    drive(1'b1, 1'b0, 6'h01); step();
    drive(1'b1, 1'b0, 6'h02); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if (flags !== 5'b00000) begin
      n_err++; $display("FAIL thr_base: got %b want %b", flags, 5'b00000);
    end
    umbral_ae = 2'd3;
    step();
    n_cmp++;
    if (flags !== 5'b00100) begin
      n_err++; $display("FAIL thr_ae3: got %b want %b", flags, 5'b00100);
    end
    umbral_af = 2'd2;
    step();
    n_cmp++;
    if (flags !== 5'b00110) begin
      n_err++; $display("FAIL thr_af2: got %b want %b", flags, 5'b00110);
    end
    umbral_af = 2'd0;
    umbral_ae = 2'd0;
    drive(1'b1, 1'b0, 6'h03); step();
    n_cmp++;
    if (flags !== 5'b00000) begin
      n_err++; $display("FAIL thr_af0_cnt3: got %b want %b", flags, 5'b00000);
    end
    drive(1'b1, 1'b0, 6'h04); step();
    drive(1'b0, 1'b0, 6'h00);
    n_cmp++;
    if (flags !== 5'b01010) begin
      n_err++; $display("FAIL thr_af0_full: got %b want %b", flags, 5'b01010);
    end
  endtask

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = 6'h00;
    umbral_af = 2'd1;
    umbral_ae = 2'd1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_threshold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Single synchronous FIFO with programmable almost-full and almost-empty thresholds.
- Sits directly upstream of the flow-control FSM and produces the per-FIFO empty and error status bits that the FSM consumes.
- The FSM's umbrales_I bus supplies the threshold values.
- Five instances are built: MF, VC0, VC1, D0, D1. Their empty/error bits are concatenated into FIFO_empty[4:0] and FIFO_error[4:0].

Parameters:
- DATA_WIDTH, 6, width of one stored word.
- ADDR_WIDTH, 2, pointer width. DEPTH = 2**ADDR_WIDTH.
- Instance settings: MF/D0/D1 use ADDR_WIDTH=2; VC0/VC1 use ADDR_WIDTH=4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- data_in  in  DATA_WIDTH  write data.
- push  in  1  write request.
- pop  in  1  read request.
- umbral_af  in  ADDR_WIDTH  almost-full threshold: slots-remaining margin.
- umbral_ae  in  ADDR_WIDTH  almost-empty threshold: occupancy level.
- data_out  out  DATA_WIDTH  registered read data.
- valid_out  out  1  data_out holds a word popped last cycle.
- fifo_empty  out  1  occupancy == 0.
- fifo_full  out  1  occupancy == DEPTH.
- almost_empty  out  1  occupancy <= umbral_ae.
- almost_full  out  1  occupancy >= DEPTH - umbral_af.
- fifo_error  out  1  sticky overflow/underflow flag.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
- State: wr_ptr and rd_ptr, ADDR_WIDTH each, wrap naturally modulo DEPTH. count, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset values, applied asynchronously while reset=1:
  - wr_ptr = rd_ptr = count = 0
  - data_out = 0, valid_out = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_empty = 1, almost_full = 0
  - fifo_error = 0
  - Memory contents are don't-care.
- Accept rules, evaluated on the current registered count:
  - push_ok = push & (!fifo_full | pop_ok)
  - pop_ok = pop & !fifo_empty
- Write: when push_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read: when pop_ok, data_out <= mem[rd_ptr], valid_out <= 1 and rd_ptr increments. Otherwise valid_out <= 0 and data_out holds its value.
- Read latency is 1 cycle from the pop edge to data_out/valid_out.
- Count update: count_next = count + push_ok - pop_ok.
- Flags are registered from count_next and the current thresholds, so they are coherent with count every cycle:
  - fifo_empty = (count_next == 0)
  - fifo_full = (count_next == DEPTH)
  - almost_empty = (count_next <= umbral_ae)
  - almost_full = (count_next >= DEPTH - umbral_af), computed at ADDR_WIDTH+1 bits. umbral_af = 0 makes almost_full equivalent to full.
- Simultaneous push and pop:
  - Not empty, not full: both accepted; count unchanged; both pointers advance.
  - Full: both accepted (pop frees the slot); no error.
  - Empty: push accepted, pop ignored (no bypass); valid_out = 0; no error.
- Error conditions. fifo_error is set on:
  - Overflow: push while fifo_full and no pop.
  - Underflow: pop while fifo_empty and no push.
  - fifo_error is sticky; only reset clears it.
  - The rejected operation leaves memory, pointers and count untouched.
- Threshold changes take effect on the flag update at the next rising edge, even with no push or pop.
- Reset asserted mid-transfer discards all contents. The first push after reset deasserts is accepted on the next edge.

Test Plan:
- Async reset: push twice, then assert reset between clock edges.
  - Required: all outputs return to reset values before the next edge; count = 0, fifo_empty = 1.
- Fill (DEPTH=4, umbral_af=1, umbral_ae=1): push 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
  - almost_empty falls after the 2nd push.
  - almost_full rises after the 3rd.
  - fifo_full rises after the 4th.
  - fifo_empty falls after the 1st.
- Overflow: with FIFO full, push 0x3F.
  - fifo_error = 1 next cycle, count stays 4, stored data unchanged.
  - fifo_error stays 1 through later valid traffic until reset.
- Drain: pop 4 times from the full FIFO.
  - data_out = 0x01, 0x02, 0x03, 0x04, each one cycle after its pop, with valid_out = 1.
  - fifo_empty = 1 after the last pop.
  - A 5th pop gives valid_out = 0 and fifo_error = 1.
- Simultaneous and wrap: at count 2, push+pop for 6 cycles.
  - Count stays 2, pointers wrap past 3→0, data order is preserved.
  - On an empty FIFO, push+pop gives count 1, valid_out = 0, no error.
- Threshold change: hold count = 2 with umbral_ae 1→3 and no traffic.
  - almost_empty rises on the next edge.
